// File: rtl/uart_rx_if.sv
// uart_rx serial-side bundle: line input plus received byte and strobe.
// frame_err exists only when UART_RX_FRAME_ERR_EN is defined.
interface uart_rx_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_rdy;
`ifdef UART_RX_FRAME_ERR_EN
   logic       frame_err;

   modport master (
      output rx,
      input  rx_data,
      input  rx_rdy,
      input  frame_err
   );

   modport slave (
      input  rx,
      output rx_data,
      output rx_rdy,
      output frame_err
   );
`else
   modport master (
      output rx,
      input  rx_data,
      input  rx_rdy
   );

   modport slave (
      input  rx,
      output rx_data,
      output rx_rdy
   );
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling, one-cycle rx_rdy strobe.
// Define UART_RX_FRAME_ERR_EN to add the frame_err pulse output.
module uart_rx #(
   parameter int BAUD_DIV = 2604,
   parameter int HALF_DIV = BAUD_DIV / 2
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LD = CW'(HALF_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic          s1_q, s2_q, s3_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          rdy_q, rdy_d;
   logic          start_edge;
   logic          tick;
`ifdef UART_RX_FRAME_ERR_EN
   logic          ferr_q, ferr_d;
`endif

   assign start_edge = s3_q & ~s2_q;
   assign tick       = (cnt_q == '0);

   // Synchronize rx into the clk domain and keep one extra stage for edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= bus.rx;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // State, counters and data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         ferr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
`ifdef UART_RX_FRAME_ERR_EN
         ferr_q  <= ferr_d;
`endif
      end
   end

   // Next-state: wait for edge, confirm start, shift 8 bits, check stop.
   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? RELOAD : cnt_q - CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      rdy_d   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start_edge) begin
               cnt_d   = HALF_LD;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               if (!s2_q) begin
                  state_d = DATA;
                  bit_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = {s2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (tick) begin
               state_d = IDLE;
               if (s2_q) begin
                  data_d = shift_q;
                  rdy_d  = 1'b1;
               end else begin
`ifdef UART_RX_FRAME_ERR_EN
                  ferr_d = 1'b1;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rx_data = data_q;
   assign bus.rx_rdy  = rdy_q;
`ifdef UART_RX_FRAME_ERR_EN
   assign bus.frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with a short bit time.
// Expected bytes, counts and latencies are hand-derived constants.
module tb_uart_rx;

   localparam int BD  = 100;
   localparam int HD  = 50;
   localparam int LAT = 3 + HD + 9 * BD;

   logic clk;
   logic rst;
   int   cyc;
   int   fall_cyc;
   int   rdy_cyc;
   int   wide_cnt;
   int   ferr_cnt;
   logic prev_rdy;
   int   n_checks;
   int   n_errors;
   int   n0;
   int   f0;
   logic [7:0] rx_log[$];

   uart_rx_if bus ();

   uart_rx #(
      .BAUD_DIV(BD),
      .HALF_DIV(HD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Log every rx_rdy pulse and flag pulses wider than one cycle.
   always @(negedge clk) begin
      if (bus.rx_rdy === 1'b1) begin
         rx_log.push_back(bus.rx_data);
         rdy_cyc = cyc;
         if (prev_rdy === 1'b1) wide_cnt++;
      end
      prev_rdy = bus.rx_rdy;
`ifdef UART_RX_FRAME_ERR_EN
      if (bus.frame_err === 1'b1) ferr_cnt++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bus.rx = b;
      repeat (BD) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      fall_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   initial begin
      cyc      = 0;
      wide_cnt = 0;
      ferr_cnt = 0;
      prev_rdy = 1'b0;
      n_checks = 0;
      n_errors = 0;
      rdy_cyc  = 0;
      fall_cyc = 0;
      rst      = 1'b1;
      bus.rx   = 1'b1;

      repeat (3) begin
         @(negedge clk);
         check("rst_data", 32'(bus.rx_data), 32'h00);
         check("rst_rdy", 32'(bus.rx_rdy), 32'h0);
      end
      rst = 1'b0;
      repeat (3 * BD) @(negedge clk);
      check("idle_rdy", 32'(rx_log.size()), 32'd0);

      n0 = rx_log.size();
      send_frame(8'hA5, 1'b1);
      repeat (BD) @(negedge clk);
      check("a5_cnt", 32'(rx_log.size() - n0), 32'd1);
      check("a5_data", 32'(rx_log[n0]), 32'hA5);
      check("a5_lat", 32'(rdy_cyc - fall_cyc), 32'(LAT));
      check("a5_hold", 32'(bus.rx_data), 32'hA5);

      n0 = rx_log.size();
      send_frame(8'hE7, 1'b1);
      send_frame(8'h24, 1'b1);
      repeat (BD) @(negedge clk);
      check("b2b_cnt", 32'(rx_log.size() - n0), 32'd2);
      check("b2b_first", 32'(rx_log[n0]), 32'hE7);
      check("b2b_second", 32'(rx_log[n0+1]), 32'h24);
      check("b2b_lat", 32'(rdy_cyc - fall_cyc), 32'(LAT));

      n0 = rx_log.size();
      bus.rx = 1'b0;
      repeat (20) @(negedge clk);
      bus.rx = 1'b1;
      repeat (2 * BD) @(negedge clk);
      check("glitch_cnt", 32'(rx_log.size() - n0), 32'd0);
      send_frame(8'h3C, 1'b1);
      repeat (BD) @(negedge clk);
      check("3c_cnt", 32'(rx_log.size() - n0), 32'd1);
      check("3c_data", 32'(bus.rx_data), 32'h3C);

      n0 = rx_log.size();
      f0 = ferr_cnt;
      send_frame(8'h5A, 1'b0);
      bus.rx = 1'b1;
      repeat (2 * BD) @(negedge clk);
      check("ferr_cnt", 32'(rx_log.size() - n0), 32'd0);
      check("ferr_data", 32'(bus.rx_data), 32'h3C);
`ifdef UART_RX_FRAME_ERR_EN
      check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
`endif

      n0 = rx_log.size();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      bus.rx = 1'b1;
      repeat (BD / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_data", 32'(bus.rx_data), 32'h00);
      check("abort_rdy", 32'(bus.rx_rdy), 32'h0);
      repeat (BD / 2 - 1) @(negedge clk);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      repeat (BD) @(negedge clk);
      check("abort_cnt", 32'(rx_log.size() - n0), 32'd0);

      send_frame(8'h81, 1'b1);
      repeat (BD) @(negedge clk);
      check("81_cnt", 32'(rx_log.size() - n0), 32'd1);
      check("81_data", 32'(bus.rx_data), 32'h81);

      check("rdy_width", 32'(wide_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: 1 start bit, 8 data bits sent LSB first, 1 stop bit, no parity.
- Oversamples the asynchronous serial input `rx` with the system clock and samples each bit at its midpoint.
- Presents each received byte on `rx_data` with a one-cycle `rx_rdy` strobe.
- Sits between the board serial pin and the SPART/host-side logic.

Parameters:
- BAUD_DIV, default 2604: system clocks per bit (50 MHz / 19200 baud). Must be >= 4.
- HALF_DIV, default BAUD_DIV/2 (1302): clocks from the start-bit falling edge to the start-bit midpoint.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high. One clock, no other clock domains.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  last correctly framed byte received.
- rx_rdy  output  1  one-cycle pulse: a new byte has been loaded into rx_data.

Behaviour:
- Reset values: rx_data=8'h00, rx_rdy=0, state=IDLE, both synchronizer flops=1, baud counter=0, bit counter=0.
- Input conditioning:
  - rx passes through a 2-flop synchronizer, then one more flop for edge detection.
  - A start edge is the synchronized value going 1 to 0.
  - No rx change is seen by the FSM earlier than 2 cycles after it occurs.
- Baud counter: ceil(log2(BAUD_DIV)) bits, counts down to 0, then reloads BAUD_DIV-1.
- FSM states:
  - IDLE: rx_rdy=0. On a start edge, load the counter with HALF_DIV-1 and go to START.
  - START: at counter=0, sample the synchronized rx.
    - If 0: go to DATA, bit counter=0, reload BAUD_DIV-1.
    - If 1: false start (glitch shorter than half a bit); go to IDLE, no output change.
  - DATA: at each counter=0, shift the sample into the MSB of an 8-bit shift register (shift right), so the first received bit ends in bit 0. Increment the bit counter. After the 8th sample go to STOP and reload.
  - STOP: at counter=0, sample rx.
    - If 1: rx_data <= shift register, and rx_rdy=1 in the following cycle for exactly one cycle.
    - If 0 (framing error): rx_data unchanged, no rx_rdy.
    - In both cases go to IDLE immediately.
- Sample points relative to the detected edge cycle t: t+HALF_DIV (start), then every BAUD_DIV cycles (8 data, then stop).
- Back-to-back frames: because IDLE is re-entered at mid-stop-bit, a start bit immediately following a one-bit-long stop bit is received. No idle gap is required.
- After a framing error where rx stays low, no new frame starts until rx returns high and falls again (edge-triggered start).
- rx_data holds its value indefinitely between frames and is stable whenever rx_rdy=1.
- rst asserted mid-frame: the next clock edge forces all reset values and the partial byte is discarded. Reception resumes only on a new falling edge after rst deasserts.
- rx activity during DATA/STOP is ignored except at the sample points.

Optional Feature:
- Macro UART_RX_FRAME_ERR_EN.
- When defined: adds output frame_err (1 bit, reset 0). It pulses high for one cycle (the cycle rx_rdy would have pulsed) when the stop-bit sample is 0.
- When not defined: the port does not exist, and framing errors are silently dropped as above.
- Data path and rx_rdy behaviour are identical either way.

Test Plan:
- Hold rst for 3 cycles, rx=1 -> rx_data=8'h00 and rx_rdy=0 throughout; idle 3 bit-times with no rx_rdy.
- Send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) at 2604 clk/bit -> exactly one rx_rdy pulse, about 9.5 bit-times after the start edge, with rx_data=8'hA5 in that cycle.
- Send 0xE7, then a one-bit stop immediately followed by 0x24 -> two single-cycle rx_rdy pulses with rx_data=8'hE7, then 8'h24. No byte lost or shifted.
- Drive a 600-cycle low glitch while idle -> no rx_rdy, FSM back in IDLE. A following 0x3C frame is received correctly.
- Send 0x5A with the stop bit held 0 -> no rx_rdy and rx_data keeps its previous value. With UART_RX_FRAME_ERR_EN, frame_err pulses once.
- Assert rst for 1 cycle during data bit 4 of a frame, then send 0x81 -> no rx_rdy for the aborted frame; rx_data=8'h81 after the new frame.
